// File: rtl/camera_writer_pkg.sv
// Shared types and default geometry for the camera frame writer.
package camera_writer_pkg;

  typedef logic [24:0] addr_t;
  typedef logic [9:0]  pixel_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  localparam int    CAM_WIDTH  = 640;
  localparam int    CAM_HEIGHT = 480;
  localparam addr_t CAM_BASE0  = 25'd0;
  localparam addr_t CAM_BASE1  = 25'd307200;

endpackage

// File: rtl/camera_frame_writer.sv
// Turns the framed camera pixel stream into addressed SDRAM port C writes.
// Optional ping-pong buffering: define CAMERA_WRITER_DOUBLE_BUFFER_EN.
module camera_frame_writer
  import camera_writer_pkg::*;
#(
  parameter int    WIDTH  = CAM_WIDTH,
  parameter int    HEIGHT = CAM_HEIGHT,
  parameter addr_t BASE0  = CAM_BASE0,
  parameter addr_t BASE1  = CAM_BASE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sof,
  input  logic        eol,
  input  logic        pix_valid,
  input  pixel_t      pix_data,
  output logic        portC_write,
  output addr_t       portC_addr,
  output pixel_t      portC_din,
  output addr_t       vga_read_offset,
  output logic        frame_done,
  output logic        line_overflow,
  output logic        frame_abort,
  output logic [7:0]  frame_count
);

  localparam logic [9:0] WIDTH_X     = 10'(WIDTH);
  localparam logic [9:0] HEIGHT_LAST = 10'(HEIGHT - 1);
  localparam addr_t      WIDTH_A     = 25'(WIDTH);

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  addr_t      addr_q, addr_d, line_base_q, line_base_d;
  logic       write_q, write_d;
  addr_t      waddr_q, waddr_d;
  pixel_t     din_q, din_d;
  logic       done_q, done_d, ovf_q, ovf_d, abort_q, abort_d;
  logic [7:0] count_q, count_d;
  addr_t      wbase;

`ifdef CAMERA_WRITER_DOUBLE_BUFFER_EN
  logic sel_q, sel_d;

  // Display always shows the buffer not currently being written.
  assign sel_d           = sel_q ^ done_d;
  assign wbase           = sel_q ? BASE1 : BASE0;
  assign vga_read_offset = sel_q ? BASE0 : BASE1;

  always_ff @(posedge clk) begin
    if (rst) sel_q <= 1'b0;
    else     sel_q <= sel_d;
  end
`else
  logic unused_base1;

  assign unused_base1    = ^BASE1;
  assign wbase           = BASE0;
  assign vga_read_offset = BASE0;
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    line_base_d = line_base_q;
    write_d     = 1'b0;
    waddr_d     = waddr_q;
    din_d       = din_q;
    done_d      = 1'b0;
    ovf_d       = 1'b0;
    abort_d     = 1'b0;
    count_d     = count_q;

    // sof restarts first so a same-cycle pixel lands at x=0 of the new frame.
    if (sof) begin
      abort_d     = (state_q == ACTIVE);
      state_d     = ACTIVE;
      x_d         = '0;
      y_d         = '0;
      addr_d      = wbase;
      line_base_d = wbase;
    end

    if (sof || state_q == ACTIVE) begin
      if (pix_valid) begin
        if (x_d < WIDTH_X) begin
          write_d = 1'b1;
          waddr_d = addr_d;
          din_d   = pix_data;
          x_d     = x_d + 10'd1;
          addr_d  = addr_d + 25'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end

      // Next line always starts a full WIDTH on, even after a short line.
      if (eol && !sof) begin
        if (y_q < HEIGHT_LAST) begin
          y_d         = y_q + 10'd1;
          x_d         = '0;
          line_base_d = line_base_q + WIDTH_A;
          addr_d      = line_base_q + WIDTH_A;
        end else begin
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      line_base_q <= '0;
      write_q     <= 1'b0;
      waddr_q     <= '0;
      din_q       <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      abort_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      line_base_q <= line_base_d;
      write_q     <= write_d;
      waddr_q     <= waddr_d;
      din_q       <= din_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      abort_q     <= abort_d;
      count_q     <= count_d;
    end
  end

  assign portC_write   = write_q;
  assign portC_addr    = waddr_q;
  assign portC_din     = din_q;
  assign frame_done    = done_q;
  assign line_overflow = ovf_q;
  assign frame_abort   = abort_q;
  assign frame_count   = count_q;

endmodule
